// File: rtl/mccpu_control.sv
// mccpu_control: multicycle sequencer for the mccpu datapath.
//
// Steps an IF/ID/EXE/MEM/WB state machine, decodes op/func from the IR and
// drives every datapath write enable and mux select combinationally from
// the current state, op, func, z and mem_ready. The state register is the
// only storage in this block.
//
// Memory handshake: the single memory port is requested implicitly by being
// in IF (fetch) or MEM (data access). mem_ready=1 means the access completes
// in this cycle; the associated strobe (wir/wpc in IF, wdr or wmem in MEM)
// is asserted in that same cycle and the FSM advances. mem_ready=0 holds the
// FSM in place with those strobes low. mem_ready is ignored in ID/EXE/WB.
//
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   synchronous reset, active HIGH despite the name
//   op, func   in   IR[31:26], IR[5:0]
//   z          in   ALU zero flag (used in EXE for beq/bne)
//   mem_ready  in   memory access completes this cycle
//   state      out  IF=000 ID=001 EXE=010 MEM=011 WB=100
//   wpc/wir/wdr/wmem/wreg  out  datapath write strobes
//   iord, regrt, m2reg, jal, wn_sel, shift, alusrca, sext  out  selects
//   aluc[3:0], alusrcb[1:0], pcsource[1:0]                 out  selects
//   wn[4:0]    out  JAL_REG while jal is asserted, else 0
//   illegal    out  one-cycle pulse in ID on an undecoded instruction
module mccpu_control #(
  parameter logic [2:0] RESET_STATE = 3'b000,
  parameter logic [4:0] JAL_REG     = 5'd31
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       wpc,
  output logic       wir,
  output logic       wdr,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       wn_sel,
  output logic [4:0] wn,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [1:0] pcsource,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0100, ALU_AND = 4'b0001,
                         ALU_OR  = 4'b0101, ALU_XOR = 4'b0010, ALU_NOR = 4'b1001,
                         ALU_SLT = 4'b1010, ALU_LUI = 4'b0110, ALU_SLL = 4'b0011,
                         ALU_SRL = 4'b0111, ALU_SRA = 4'b1111;

  state_e state_q, state_d;

  // Instruction decode
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_nor, i_slt, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic is_shift, r_alu, i_alu, legal;

  assign r_type = (op == 6'h00);
  assign i_add  = r_type & (func == 6'h20);
  assign i_sub  = r_type & (func == 6'h22);
  assign i_and  = r_type & (func == 6'h24);
  assign i_or   = r_type & (func == 6'h25);
  assign i_xor  = r_type & (func == 6'h26);
  assign i_nor  = r_type & (func == 6'h27);
  assign i_slt  = r_type & (func == 6'h2a);
  assign i_sll  = r_type & (func == 6'h00);
  assign i_srl  = r_type & (func == 6'h02);
  assign i_sra  = r_type & (func == 6'h03);
  assign i_jr   = r_type & (func == 6'h08);
  assign i_addi = (op == 6'h08);
  assign i_andi = (op == 6'h0c);
  assign i_ori  = (op == 6'h0d);
  assign i_xori = (op == 6'h0e);
  assign i_lui  = (op == 6'h0f);
  assign i_lw   = (op == 6'h23);
  assign i_sw   = (op == 6'h2b);
  assign i_beq  = (op == 6'h04);
  assign i_bne  = (op == 6'h05);
  assign i_j    = (op == 6'h02);
  assign i_jal  = (op == 6'h03);

  assign is_shift = i_sll | i_srl | i_sra;
  assign r_alu    = i_add | i_sub | i_and | i_or | i_xor | i_nor | i_slt | is_shift;
  assign i_alu    = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign legal    = r_alu | i_jr | i_alu | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

  // ALU operation used in EXE
  logic [3:0] exe_aluc;
  always_comb begin
    exe_aluc = ALU_ADD;
    if (i_sub | i_beq | i_bne) exe_aluc = ALU_SUB;
    else if (i_and | i_andi)   exe_aluc = ALU_AND;
    else if (i_or  | i_ori)    exe_aluc = ALU_OR;
    else if (i_xor | i_xori)   exe_aluc = ALU_XOR;
    else if (i_nor)            exe_aluc = ALU_NOR;
    else if (i_slt)            exe_aluc = ALU_SLT;
    else if (i_lui)            exe_aluc = ALU_LUI;
    else if (i_sll)            exe_aluc = ALU_SLL;
    else if (i_srl)            exe_aluc = ALU_SRL;
    else if (i_sra)            exe_aluc = ALU_SRA;
  end

  always_ff @(posedge clock) begin
    if (resetn) state_q <= state_e'(RESET_STATE);
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wpc      = 1'b0;
    wir      = 1'b0;
    wdr      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    aluc     = ALU_ADD;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    sext     = 1'b0;
    pcsource = 2'b00;
    illegal  = 1'b0;
    unique case (state_q)
      S_IF: begin
        alusrcb = 2'b01;        // PC + 4
        wir     = mem_ready;
        wpc     = mem_ready;
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        alusrcb = 2'b11;        // branch target into ALU-out register
        if (!legal) begin
          illegal = 1'b1;
          state_d = S_IF;
        end else if (i_j | i_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = i_jal;     // PC already holds the return address
          jal      = i_jal;
          state_d  = S_IF;
        end else if (i_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
          state_d  = S_IF;
        end else begin
          state_d  = S_EXE;
        end
      end
      S_EXE: begin
        aluc    = exe_aluc;
        shift   = is_shift;
        alusrca = ~is_shift;    // shifts take shamt on A instead of rs
        alusrcb = (r_type | i_beq | i_bne) ? 2'b00 : 2'b10;
        sext    = i_addi | i_lw | i_sw | i_beq | i_bne;
        if (i_beq | i_bne) begin
          wpc      = (i_beq & z) | (i_bne & ~z);
          pcsource = 2'b01;
          state_d  = S_IF;
        end else if (i_lw | i_sw) begin
          state_d  = S_MEM;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        wmem = i_sw & mem_ready;
        wdr  = i_lw & mem_ready;
        if (mem_ready) state_d = i_lw ? S_WB : S_IF;
      end
      S_WB: begin
        wreg    = 1'b1;
        regrt   = ~r_type;
        m2reg   = i_lw;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset squashes every strobe and select, even mid-instruction.
    if (resetn) begin
      wpc = 1'b0; wir = 1'b0; wdr = 1'b0; wmem = 1'b0; wreg = 1'b0;
      iord = 1'b0; regrt = 1'b0; m2reg = 1'b0; jal = 1'b0;
      aluc = 4'b0000; shift = 1'b0; alusrca = 1'b0; alusrcb = 2'b00;
      sext = 1'b0; pcsource = 2'b00; illegal = 1'b0;
    end
  end

  assign state  = state_q;
  assign wn_sel = jal;
  assign wn     = jal ? JAL_REG : 5'd0;

endmodule

// File: tb/tb_mccpu_control.sv
module tb_mccpu_control;

  logic       clock = 1'b0;
  logic       resetn, z, mem_ready;
  logic [5:0] op, func;
  logic [2:0] state;
  logic       wpc, wir, wdr, wmem, wreg, iord, regrt, m2reg, jal, wn_sel;
  logic [4:0] wn;
  logic [3:0] aluc;
  logic       shift, alusrca, sext, illegal;
  logic [1:0] alusrcb, pcsource;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mccpu_control dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z),
    .mem_ready(mem_ready), .state(state), .wpc(wpc), .wir(wir), .wdr(wdr),
    .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt), .m2reg(m2reg),
    .jal(jal), .wn_sel(wn_sel), .wn(wn), .aluc(aluc), .shift(shift),
    .alusrca(alusrca), .alusrcb(alusrcb), .sext(sext), .pcsource(pcsource),
    .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {wpc, wir, wdr, wmem, wreg, illegal};
  endfunction

  initial begin
    resetn = 1'b1; op = 6'h00; func = 6'h00; z = 1'b0; mem_ready = 1'b1;

    // Reset held two cycles: strobes low even though IF sees mem_ready=1
    tick();
    chk("rst_state", state, 3'b000);
    chk("rst_strobes_c1", strobes(), 6'b0);
    tick();
    chk("rst_strobes_c2", strobes(), 6'b0);
    chk("rst_alusrcb", alusrcb, 2'b00);
    resetn = 1'b0;
    #1;
    chk("post_rst_state", state, 3'b000);
    chk("if_wir", wir, 1'b1);
    chk("if_wpc", wpc, 1'b1);
    chk("if_alusrcb", alusrcb, 2'b01);

    // nor: IF, ID, EXE, WB, IF
    op = 6'h00; func = 6'h27;
    tick();
    chk("nor_id_state", state, 3'b001);
    chk("nor_id_alusrcb", alusrcb, 2'b11);
    tick();
    chk("nor_exe_state", state, 3'b010);
    chk("nor_exe_aluc", aluc, 4'b1001);
    chk("nor_exe_alusrca", alusrca, 1'b1);
    chk("nor_exe_alusrcb", alusrcb, 2'b00);
    tick();
    chk("nor_wb_state", state, 3'b100);
    chk("nor_wb_wreg", wreg, 1'b1);
    chk("nor_wb_regrt", regrt, 1'b0);
    chk("nor_wb_m2reg", m2reg, 1'b0);
    tick();
    chk("nor_done_state", state, 3'b000);

    // lw with two stalled MEM cycles: 7 cycles total
    op = 6'h23; func = 6'h00;
    tick();
    tick();
    chk("lw_exe_state", state, 3'b010);
    chk("lw_exe_alusrcb", alusrcb, 2'b10);
    chk("lw_exe_sext", sext, 1'b1);
    chk("lw_exe_aluc", aluc, 4'b0000);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("lw_mem1_state", state, 3'b011);
    chk("lw_mem1_iord", iord, 1'b1);
    chk("lw_mem1_wdr", wdr, 1'b0);
    tick();
    chk("lw_mem2_state", state, 3'b011);
    chk("lw_mem2_wdr", wdr, 1'b0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("lw_mem3_state", state, 3'b011);
    chk("lw_mem3_wdr", wdr, 1'b1);
    tick();
    chk("lw_wb_state", state, 3'b100);
    chk("lw_wb_m2reg", m2reg, 1'b1);
    chk("lw_wb_regrt", regrt, 1'b1);
    chk("lw_wb_wreg", wreg, 1'b1);
    tick();
    chk("lw_done_state", state, 3'b000);

    // beq taken
    op = 6'h04; z = 1'b1;
    tick();
    tick();
    chk("beq_t_state", state, 3'b010);
    chk("beq_t_wpc", wpc, 1'b1);
    chk("beq_t_pcsource", pcsource, 2'b01);
    chk("beq_t_aluc", aluc, 4'b0100);
    tick();
    chk("beq_t_done", state, 3'b000);

    // beq not taken
    z = 1'b0;
    tick();
    tick();
    chk("beq_nt_wpc", wpc, 1'b0);
    tick();
    chk("beq_nt_done", state, 3'b000);

    // jal
    op = 6'h03;
    tick();
    chk("jal_id_state", state, 3'b001);
    chk("jal_id_wpc", wpc, 1'b1);
    chk("jal_id_pcsource", pcsource, 2'b11);
    chk("jal_id_wreg", wreg, 1'b1);
    chk("jal_id_jal", jal, 1'b1);
    chk("jal_id_wn_sel", wn_sel, 1'b1);
    chk("jal_id_wn", wn, 5'd31);
    tick();
    chk("jal_done", state, 3'b000);

    // jr
    op = 6'h00; func = 6'h08;
    tick();
    chk("jr_id_wpc", wpc, 1'b1);
    chk("jr_id_pcsource", pcsource, 2'b10);
    chk("jr_id_wreg", wreg, 1'b0);
    tick();
    chk("jr_done", state, 3'b000);

    // illegal opcode
    op = 6'h3f;
    tick();
    chk("ill_id_illegal", illegal, 1'b1);
    chk("ill_id_writes", {wpc, wir, wdr, wmem, wreg}, 5'b0);
    tick();
    chk("ill_done_state", state, 3'b000);
    chk("ill_done_pulse", illegal, 1'b0);

    // sw interrupted by reset in MEM
    op = 6'h2b;
    tick();
    tick();
    tick();
    chk("sw_mem_state", state, 3'b011);
    chk("sw_mem_wmem", wmem, 1'b1);
    resetn = 1'b1;
    #1;
    chk("sw_rst_wmem", wmem, 1'b0);
    chk("sw_rst_iord", iord, 1'b0);
    tick();
    chk("sw_rst_state", state, 3'b000);
    resetn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mccpu_control.md
Name: mccpu_control

Overview:
- Multicycle sequencer for the mccpu datapath: PC, IR, register file, ALU, ALU-out register, memory-data register, single shared memory port.
- Decodes `op`/`func` from the IR and steps an IF/ID/EXE/MEM/WB state machine.
- Drives every datapath write enable and mux select each cycle.
- Stalls on a memory-ready handshake so the one memory port serves both fetch and data access.

Parameters:
- RESET_STATE, 3'b000, state entered on reset (IF).
- JAL_REG, 5'd31, register number driven on `wn` for jal.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous active-high reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag, live in EXE
- mem_ready  in  1  memory has completed the current access this cycle
- state  out  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100
- wpc  out  1  PC write
- wir  out  1  IR write
- wdr  out  1  memory-data register write
- wmem  out  1  memory write
- wreg  out  1  register file write
- iord  out  1  memory address mux: 0=PC, 1=ALU-out register
- regrt  out  1  destination register: 1=rt, 0=rd
- m2reg  out  1  register write data: 1=data register, 0=ALU-out register
- jal  out  1  register write data=PC, destination=JAL_REG
- wn_sel  out  1  mirrors jal
- aluc  out  4  ALU operation
- shift  out  1  ALU A=shamt
- alusrca  out  1  ALU A: 0=PC, 1=rs register
- alusrcb  out  2  ALU B: 00=rt register, 01=const 4, 10=extended imm, 11=sext imm<<2
- sext  out  1  imm extension: 1=sign, 0=zero
- pcsource  out  2  PC source: 00=ALU result, 01=ALU-out register, 10=rs register, 11={PC[31:28],addr,2'b00}
- illegal  out  1  one-cycle pulse in ID on an undecoded instruction

Behaviour:
- Reset, clock and state register:
  - While `resetn`=1 at a rising edge, state<=IF.
  - While `resetn`=1, all write strobes (wpc, wir, wdr, wmem, wreg, illegal) are forced 0, mid-instruction included.
  - All selects are 0 during reset.
  - Outputs are combinational from state, op, func, z and mem_ready; the state register is the only storage.
- aluc encoding:
  - add 0000, sub 0100, and 0001, or 0101, xor 0010, nor 1001, slt 1010.
  - lui 0110, sll 0011, srl 0111, sra 1111.
- Decoded instructions:
  - R-type: add, sub, and, or, xor, nor, slt, sll, srl, sra, jr.
  - I-type: addi, andi, ori, xori, lui, lw, sw, beq, bne.
  - Jumps: j, jal.
  - Everything else is illegal.
- IF:
  - iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - wir=wpc=mem_ready.
  - mem_ready=0: stay in IF. mem_ready=1: go to ID.
- ID:
  - alusrca=0, alusrcb=11, aluc=add (branch target into ALU-out register).
  - j: wpc=1, pcsource=11, go to IF.
  - jal: as j, plus wreg=1, jal=1 (writes already-incremented PC), go to IF.
  - jr: wpc=1, pcsource=10, go to IF.
  - illegal: illegal=1, no writes, go to IF.
  - All others go to EXE.
- EXE:
  - alusrca=1, except shifts: shift=1.
  - alusrcb=00 for R-type and branches, 10 for I-type.
  - sext=1 for addi, lw, sw, beq, bne; sext=0 for andi, ori, xori, lui.
  - beq/bne: aluc=sub; wpc=(beq&z)|(bne&~z), pcsource=01; go to IF.
  - lw/sw: aluc=add; go to MEM.
  - Others go to WB.
- MEM:
  - iord=1.
  - sw: wmem=mem_ready.
  - lw: wdr=mem_ready.
  - mem_ready=0: stay in MEM. Otherwise lw goes to WB, sw goes to IF.
- WB:
  - wreg=1.
  - regrt=1 for I-type.
  - m2reg=1 for lw.
  - Go to IF.
- Cycle counts at mem_ready=1: R/I ALU 4, lw 5, sw 4, branch 3, j/jal/jr 2.
- Each cycle mem_ready is held low in IF or MEM adds exactly one cycle.
- mem_ready outside IF/MEM is ignored.

Test Plan:
- resetn=1 two cycles, then 0 -> state=000 the first cycle after release; all strobes 0 throughout reset.
- op=0, func=0x27 (nor), mem_ready=1 -> states 000,001,010,100,000.
  - EXE: aluc=1001.
  - WB: wreg=1, regrt=0, m2reg=0.
- op=0x23 (lw) with mem_ready=0 for first 2 MEM cycles -> MEM held 3 cycles; wdr=1 only in third; then WB with m2reg=1, regrt=1; 7 cycles total.
- op=0x04 (beq): z=1 -> EXE wpc=1, pcsource=01. z=0 -> wpc=0. Both return to IF after 3 cycles.
- op=0x03 (jal) -> ID: wpc=1, pcsource=11, wreg=1, jal=1; back in IF at cycle 3.
- op=0x3f -> illegal pulses 1 cycle in ID, no writes; resetn=1 asserted in MEM of an sw -> wmem=0, state=IF next cycle.
